// File: rtl/instr_encoder.sv
// instr_encoder: Y86-64 instruction encoder/loader.
// Takes one decoded instruction per handshake and writes its fetch-compatible
// byte image (opcode, optional register byte, optional little-endian valC)
// into instruction memory, one byte per cycle, tracking the next free address.
// Optional macro INSTR_ENC_CHECK_EN: reject icodes above 0xB with an
// inv_instr pulse instead of encoding them as 1-byte instructions.
module instr_encoder #(
  parameter int              ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_val,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              instr_done,
  output logic              inv_instr
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Encoded length in bytes for each icode; unknown codes become 1-byte opcodes.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h3, 4'h4, 4'h5:        instr_len = 4'd10;
      4'h7, 4'h8:              instr_len = 4'd9;
      4'h2, 4'h6, 4'hA, 4'hB:  instr_len = 4'd2;
      default:                 instr_len = 4'd1;
    endcase
  endfunction

  // Instructions that carry the {rA,rB} byte right after the opcode.
  function automatic logic has_regs(input logic [3:0] code);
    case (code)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  state_t            state_reg, state_next;
  logic [3:0]        idx_reg, idx_next;
  logic [3:0]        len_reg, len_next;
  logic [3:0]        icode_reg, icode_next;
  logic [3:0]        ifun_reg, ifun_next;
  logic [3:0]        ra_reg, ra_next;
  logic [3:0]        rb_reg, rb_next;
  logic [63:0]       valc_reg, valc_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              instr_done_reg, instr_done_next;
  logic              icode_ok;

  // In IDLE the live inputs feed the byte image so byte 0 can be registered on
  // the accept edge; during EMIT the latched copy is used.
  logic [3:0]  src_icode, src_ifun, src_ra, src_rb;
  logic [63:0] src_valc;
  logic        src_has_regs;
  logic [7:0]  frame [10];

  assign src_icode    = (state_reg == IDLE) ? icode : icode_reg;
  assign src_ifun     = (state_reg == IDLE) ? ifun  : ifun_reg;
  assign src_ra       = (state_reg == IDLE) ? rA    : ra_reg;
  assign src_rb       = (state_reg == IDLE) ? rB    : rb_reg;
  assign src_valc     = (state_reg == IDLE) ? valC  : valc_reg;
  assign src_has_regs = has_regs(src_icode);

  assign frame[0] = {src_icode, src_ifun};
  assign frame[1] = src_has_regs ? {src_ra, src_rb} : src_valc[7:0];

  // Constant bytes shift by one position depending on the register byte.
  genvar gi;
  generate
    for (gi = 2; gi < 10; gi++) begin : g_frame
      if (gi < 9) begin : g_mid
        assign frame[gi] = src_has_regs ? src_valc[8*(gi-2) +: 8]
                                        : src_valc[8*(gi-1) +: 8];
      end else begin : g_last
        assign frame[gi] = src_valc[8*(gi-2) +: 8];
      end
    end
  endgenerate

`ifdef INSTR_ENC_CHECK_EN
  assign icode_ok = (icode <= 4'hB);
`else
  assign icode_ok = 1'b1;
`endif

  // A pointer load owns the idle cycle, so no instruction is accepted with it.
  assign in_ready = (state_reg == IDLE) && !ptr_load;

  // Next-state and next-output logic for the IDLE/EMIT sequencer.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    len_next        = len_reg;
    icode_next      = icode_reg;
    ifun_next       = ifun_reg;
    ra_next         = ra_reg;
    rb_next         = rb_reg;
    valc_next       = valc_reg;
    wr_ptr_next     = wr_ptr_reg;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    instr_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ptr_load) begin
          wr_ptr_next = ptr_val;
        end else if (in_valid && icode_ok) begin
          icode_next      = icode;
          ifun_next       = ifun;
          ra_next         = rA;
          rb_next         = rB;
          valc_next       = valC;
          len_next        = instr_len(icode);
          idx_next        = 4'd0;
          state_next      = EMIT;
          mem_we_next     = 1'b1;
          mem_addr_next   = wr_ptr_reg;
          mem_wdata_next  = frame[0];
          instr_done_next = (instr_len(icode) == 4'd1);
        end
      end
      EMIT: begin
        if (idx_reg == len_reg - 4'd1) begin
          state_next  = IDLE;
          wr_ptr_next = wr_ptr_reg + ADDR_W'(len_reg);
        end else begin
          idx_next        = idx_reg + 4'd1;
          mem_we_next     = 1'b1;
          mem_addr_next   = wr_ptr_reg + ADDR_W'(idx_next);
          mem_wdata_next  = frame[idx_next];
          instr_done_next = (idx_next == len_reg - 4'd1);
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      len_reg        <= '0;
      icode_reg      <= '0;
      ifun_reg       <= '0;
      ra_reg         <= '0;
      rb_reg         <= '0;
      valc_reg       <= '0;
      wr_ptr_reg     <= BASE_ADDR;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      instr_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      len_reg        <= len_next;
      icode_reg      <= icode_next;
      ifun_reg       <= ifun_next;
      ra_reg         <= ra_next;
      rb_reg         <= rb_next;
      valc_reg       <= valc_next;
      wr_ptr_reg     <= wr_ptr_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      instr_done_reg <= instr_done_next;
    end
  end

`ifdef INSTR_ENC_CHECK_EN
  logic inv_instr_reg;

  // One-cycle pulse when an out-of-range icode is taken off the interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_instr_reg <= 1'b0;
    else        inv_instr_reg <= in_valid && in_ready && !icode_ok;
  end

  assign inv_instr = inv_instr_reg;
`else
  assign inv_instr = 1'b0;
`endif

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign wr_ptr     = wr_ptr_reg;
  assign instr_done = instr_done_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan steps plus random instructions,
// each checked cycle by cycle against a byte-image model built from the
// Y86-64 encoding rules. Honours INSTR_ENC_CHECK_EN like the design.
module tb_instr_encoder;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [3:0]    icode = '0, ifun = '0, rA = '0, rB = '0;
  logic [63:0]   valC = '0;
  logic          ptr_load = 1'b0;
  logic [AW-1:0] ptr_val = '0;
  logic          in_ready, mem_we, instr_done, inv_instr;
  logic [AW-1:0] mem_addr, wr_ptr;
  logic [7:0]    mem_wdata;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] model_ptr = '0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .ptr_load(ptr_load), .ptr_val(ptr_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr), .instr_done(instr_done), .inv_instr(inv_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction at an idle cycle and follow it to completion.
  task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input bit keep_valid);
    logic [7:0]    q[$];
    logic [AW-1:0] exp_addr;
    bit            invalid;
    q = {};
    q.push_back({ic, f});
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) q.push_back({ra, rb});
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
      for (int j = 0; j < 8; j++) q.push_back(vc[8*j +: 8]);
    invalid = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
    invalid = (ic > 4'hB);
`endif
    icode = ic; ifun = f; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    #1;
    check("in_ready_idle", in_ready, 1'b1);
    tick();
    if (!keep_valid || invalid) in_valid = 1'b0;
    {icode, ifun, rA, rB} = 16'($urandom);
    valC = {$urandom, $urandom};
    if (invalid) begin
      check("inv_pulse", inv_instr, 1'b1);
      check("inv_no_write", mem_we, 1'b0);
      check("inv_ready", in_ready, 1'b1);
      check("inv_ptr", wr_ptr, model_ptr);
      tick();
      check("inv_clear", inv_instr, 1'b0);
      check("inv_ptr2", wr_ptr, model_ptr);
      $display("txn icode=%h rejected ptr=%0d", ic, model_ptr);
      return;
    end
    for (int k = 0; k < q.size(); k++) begin
      exp_addr = model_ptr + AW'(k);
      check("we", mem_we, 1'b1);
      check("addr", mem_addr, exp_addr);
      check("wdata", mem_wdata, q[k]);
      check("done", instr_done, (k == q.size() - 1) ? 1'b1 : 1'b0);
      check("busy", in_ready, 1'b0);
      check("inv_quiet", inv_instr, 1'b0);
      check("ptr_hold", wr_ptr, model_ptr);
      // A pointer load during EMIT must be ignored.
      ptr_load = 1'($urandom_range(0, 1));
      ptr_val = AW'($urandom);
      tick();
    end
    ptr_load = 1'b0;
    #1;
    model_ptr = model_ptr + AW'(q.size());
    check("we_after", mem_we, 1'b0);
    check("done_after", instr_done, 1'b0);
    check("ready_after", in_ready, 1'b1);
    check("wr_ptr", wr_ptr, model_ptr);
    $display("txn icode=%h ifun=%h len=%0d next_ptr=%0d", ic, f, q.size(), model_ptr);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_ptr", wr_ptr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_ready", in_ready, 1'b1);
    check("rel_ptr", wr_ptr, '0);
    check("rel_we", mem_we, 1'b0);
    check("rel_done", instr_done, 1'b0);
    check("rel_inv", inv_instr, 1'b0);
    $display("txn reset released");

    // irmovq at 0, then jXX at 10
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h100, 1'b0);
    check("irmovq_ptr", wr_ptr, 11'd10);
    send(4'h7, 4'h3, 4'hF, 4'hF, 64'h20, 1'b0);
    check("jxx_ptr", wr_ptr, 11'd19);

    // halt, nop, ret with in_valid held high
    send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b1);
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1'b1);
    send(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);

    // ptr_load wins over a simultaneous in_valid
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
    ptr_load = 1'b1; ptr_val = 11'd2046;
    #1;
    check("load_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0; ptr_load = 1'b0;
    model_ptr = 11'd2046;
    #1;
    check("load_we", mem_we, 1'b0);
    check("load_ptr", wr_ptr, 11'd2046);
    $display("txn ptr_load 2046");

    // Wrap-around across the top of memory
    send(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0);
    check("wrap_ptr", wr_ptr, 11'd0);
    send(4'h6, 4'h0, 4'h3, 4'h4, 64'h0, 1'b0);

    // Out-of-range icode
    send(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);

    // Random instructions with occasional pointer loads
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ptr_load = 1'b1;
        ptr_val = AW'($urandom);
        tick();
        ptr_load = 1'b0;
        model_ptr = ptr_val;
        #1;
        check("rand_load_ptr", wr_ptr, model_ptr);
        $display("txn ptr_load %0d", model_ptr);
      end
      send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      in_valid = 1'b0;
    end

    // Reset in the middle of an instruction
    icode = 4'h4; ifun = 4'h0; rA = 4'h1; rB = 4'h2; valC = 64'h1122334455667788;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_ptr", wr_ptr, '0);
    check("mid_rst_done", instr_done, 1'b0);
    check("mid_rst_addr", mem_addr, '0);
    check("mid_rst_wdata", mem_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_ptr = '0;
    check("mid_rel_ready", in_ready, 1'b1);
    check("mid_rel_we", mem_we, 1'b0);
    $display("txn reset during emit");
    send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Y86-64 instruction encoder/loader: accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC) and serialises it byte by byte into the 2048-byte instruction memory that the fetch stage reads. It is the write-side counterpart of fetch. It produces exactly the byte layout fetch splits and aligns, and it tracks the next free address, which equals fetch's valP for the written instruction. It is used by benches and by the boot loader to populate instruction memory before the processor runs.

## Interface
- ADDR_W, 11: instruction-memory byte-address width (2^11 = 2048 bytes).
- BASE_ADDR, 0: write-pointer value after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  instruction fields present.
- in_ready  out  1  encoder can accept an instruction this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A; 0xF means none.
- rB  in  4  register B; 0xF means none.
- valC  in  64  constant word.
- ptr_load  in  1  load the write pointer from ptr_val; honoured only when idle.
- ptr_val  in  ADDR_W  new write-pointer value.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte data.
- wr_ptr  out  ADDR_W  next free address.
- instr_done  out  1  one-cycle pulse on the last byte of an instruction.
- inv_instr  out  1  one-cycle pulse when an invalid icode is rejected (only with the check compiled in).

## Operation
- Instruction lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 rrmovq/cmovXX, 6 OPq, A pushq, B popq: 2 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
  - 7 jXX, 8 call: 9 bytes.
- Byte order:
  - Byte 0 is {icode,ifun}.
  - Byte 1 is {rA,rB} if the instruction has register IDs.
  - Then valC in little-endian order, 8 bytes, if it has a constant.
- FSM states: IDLE and EMIT.
  - IDLE: in_ready = ~ptr_load.
  - IDLE → EMIT on in_valid & in_ready. All fields are latched at this point, so later input changes have no effect.
  - EMIT: a byte index counter runs 0..len-1, one byte per cycle, with mem_we=1 and mem_addr = wr_ptr + idx.
  - EMIT → IDLE after the last byte. wr_ptr += len on that same edge.
- ptr_load in IDLE:
  - wr_ptr ← ptr_val.
  - in_ready is low that cycle, so load takes precedence over a simultaneous in_valid.
  - ptr_load during EMIT is ignored.
- Address arithmetic is modulo 2^ADDR_W. An instruction starting at 2047 continues writing at 0, 1, ...
- Reset, asserted at any time:
  - State → IDLE; wr_ptr = BASE_ADDR.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, instr_done = 0, inv_instr = 0; in_ready = 1 after release.
  - A partially written instruction is abandoned; bytes already written are not undone.

## Timing
- The instruction is accepted on edge T. Its bytes are driven in cycles T+1 .. T+len, all registered outputs.
- instr_done = 1 in cycle T+len, together with the last byte. wr_ptr shows the updated value from cycle T+len+1.
- in_ready is low in cycles T+1..T+len and high again at T+len+1. Throughput is len+1 cycles per instruction.
- mem_we is never high in IDLE. Outside writes, mem_wdata holds its last value.

## Configuration
- INSTR_ENC_CHECK_EN defined:
  - An icode greater than 0xB is accepted, then inv_instr pulses at T+1.
  - No bytes are written, wr_ptr is unchanged, and the FSM is back in IDLE at T+1.
- INSTR_ENC_CHECK_EN not defined:
  - An icode greater than 0xB is encoded as a 1-byte instruction {icode,ifun}.
  - inv_instr is tied to 0.

## Test plan
- Reset and release -> in_ready=1, wr_ptr=0, mem_we=0, instr_done=0; reset asserted mid-EMIT -> mem_we=0 immediately and wr_ptr=0.
- irmovq (3,0,F,2, valC=0x100) at ptr 0 -> bytes 30 F2 00 01 00 00 00 00 00 00 at addresses 0..9; instr_done with byte 9; wr_ptr=10.
- jXX (7,3, valC=0x20) at ptr 10 -> bytes 73 20 00 00 00 00 00 00 00 at 10..18; no register byte; wr_ptr=19.
- halt, nop, ret back-to-back with in_valid held high -> bytes 00, 10, 90 at consecutive addresses, each followed by one cycle with in_ready=0.
- ptr_load 2046 asserted together with in_valid -> instruction not accepted; then rrmovq (2,0,1,2) -> 20 at 2046 and 12 at 2047, wr_ptr=0; then OPq (6,0,3,4) -> 60 at 0 and 34 at 1.
- icode 0xC, ifun 0 -> with the macro: inv_instr pulse, no write, wr_ptr unchanged; without the macro: byte C0 written, wr_ptr +1.
